// File: rtl/pipe_fetch_queue.sv
// pipe_fetch_queue: fetch PC plus DEPTH-entry {pc4, inst} prefetch queue with ready/valid handoff to ID
// Ports: clk, rst (sync, active-low); iaddr/instr/irdy = instruction memory;
// redirect/redirect_pc = PC change from ID; dvalid/dinst/dpc4/dready = head handoff; count = occupancy.
module pipe_fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter bit DELAY_SLOT = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [31:0]   iaddr,
  input  logic [31:0]   instr,
  input  logic          irdy,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          dvalid,
  output logic [31:0]   dinst,
  output logic [31:0]   dpc4,
  input  logic          dready,
  output logic [CW-1:0] count
);
  logic [31:0]   r_pc, r_target;
  logic          r_pend;
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc4 [DEPTH];
  logic          w_pop, w_push, w_flush, w_keep;
  logic [31:0]   w_pc4;
  assign dvalid = r_count != '0;
  assign w_pop = dvalid & dready;
  assign w_push = irdy & ((r_count < CW'(DEPTH)) | w_pop);
  assign w_pc4 = r_pc + 32'd4;
  // a redirect without a delay slot to keep throws away the whole queue
  assign w_flush = redirect & ~(DELAY_SLOT & w_pop);
  // popped head is the branch; the entry behind it survives as the delay slot
  assign w_keep = redirect & DELAY_SLOT & w_pop & (r_count >= CW'(2));
  assign iaddr = r_pc;
  assign count = r_count;
  assign dinst = dvalid ? r_inst[r_head] : 32'h0;
  assign dpc4 = dvalid ? r_pc4[r_head] : 32'h0;
  always_ff @(posedge clk)
    if (w_push) begin
      r_inst[r_tail] <= instr;
      r_pc4[r_tail] <= w_pc4;
    end
  always_ff @(posedge clk)
    if (!rst) begin
      r_pc <= RESET_PC;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_pend <= 1'b0;
      r_target <= '0;
    end else if (w_flush) begin
      r_tail <= r_head;
      r_count <= '0;
      r_pc <= redirect_pc;
      r_pend <= 1'b0;
    end else if (w_keep) begin
      r_head <= r_head + AW'(1);
      r_tail <= r_head + AW'(2);
      r_count <= CW'(1);
      r_pc <= redirect_pc;
      r_pend <= 1'b0;
    end else begin
      // remaining redirect cases have exactly one entry being popped:
      // a push this cycle is the delay slot, otherwise the target is deferred
      r_head <= r_head + AW'(w_pop);
      r_tail <= r_tail + AW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_pc <= redirect ? redirect_pc : r_pend ? r_target : w_pc4;
      r_pend <= (redirect | r_pend) & ~w_push;
      if (redirect) r_target <= redirect_pc;
    end
endmodule

// File: tb/tb_pipe_fetch_queue.sv
// tb_pipe_fetch_queue: directed checks of pipe_fetch_queue with and without delay-slot mode
module tb_pipe_fetch_queue;
  logic clk = 1'b0;
  logic rst, irdy, redirect, dready;
  logic [31:0] redirect_pc;
  logic [31:0] iaddr1, instr1, dinst1, dpc41, iaddr0, instr0, dinst0, dpc40;
  logic dvalid1, dvalid0;
  logic [2:0] count1, count0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign instr1 = iaddr1;
  assign instr0 = iaddr0;
  pipe_fetch_queue #(.DEPTH(4), .DELAY_SLOT(1'b1)) u1 (
    .clk(clk), .rst(rst), .iaddr(iaddr1), .instr(instr1), .irdy(irdy),
    .redirect(redirect), .redirect_pc(redirect_pc), .dvalid(dvalid1),
    .dinst(dinst1), .dpc4(dpc41), .dready(dready), .count(count1)
  );
  pipe_fetch_queue #(.DEPTH(4), .DELAY_SLOT(1'b0)) u0 (
    .clk(clk), .rst(rst), .iaddr(iaddr0), .instr(instr0), .irdy(irdy),
    .redirect(redirect), .redirect_pc(redirect_pc), .dvalid(dvalid0),
    .dinst(dinst0), .dpc4(dpc40), .dready(dready), .count(count0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b0;
    irdy = 1'b0;
    dready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    step;
    rst = 1'b1;
  endtask
  initial begin
    do_reset;
    chk("rst_iaddr", iaddr1, 32'h3000);
    chk("rst_dvalid", 32'(dvalid1), 32'h0);
    chk("rst_dinst", dinst1, 32'h0);
    chk("rst_dpc4", dpc41, 32'h0);
    chk("rst_count", 32'(count1), 32'h0);
    irdy = 1'b1;
    dready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step;
      chk("seq_iaddr", iaddr1, 32'h3000 + 32'(4 * k));
      chk("seq_dinst", dinst1, 32'h3000 + 32'(4 * (k - 1)));
      chk("seq_dpc4", dpc41, 32'h3004 + 32'(4 * (k - 1)));
      chk("seq_count", 32'(count1), 32'h1);
    end
    do_reset;
    irdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step;
      chk("fill_count", 32'(count1), 32'(k));
    end
    chk("fill_iaddr", iaddr1, 32'h3010);
    step;
    chk("full_hold_iaddr", iaddr1, 32'h3010);
    chk("full_hold_count", 32'(count1), 32'h4);
    chk("full_hold_dinst", dinst1, 32'h3000);
    dready = 1'b1;
    step;
    chk("full_pp_count", 32'(count1), 32'h4);
    chk("full_pp_dinst", dinst1, 32'h3004);
    chk("full_pp_iaddr", iaddr1, 32'h3014);
    step;
    chk("full_pp2_dinst", dinst1, 32'h3008);
    chk("full_pp2_iaddr", iaddr1, 32'h3018);
    irdy = 1'b0;
    step;
    chk("tog0_count", 32'(count1), 32'h3);
    chk("tog0_iaddr", iaddr1, 32'h3018);
    chk("tog0_dinst", dinst1, 32'h300C);
    step;
    chk("tog1_count", 32'(count1), 32'h2);
    chk("tog1_dinst", dinst1, 32'h3010);
    irdy = 1'b1;
    step;
    chk("tog2_count", 32'(count1), 32'h2);
    chk("tog2_iaddr", iaddr1, 32'h301C);
    chk("tog2_dinst", dinst1, 32'h3014);
    irdy = 1'b0;
    step;
    chk("drain_dinst", dinst1, 32'h3018);
    step;
    chk("drain_dvalid", 32'(dvalid1), 32'h0);
    chk("drain_dinst0", dinst1, 32'h0);
    chk("drain_count", 32'(count1), 32'h0);
    do_reset;
    irdy = 1'b1;
    for (int k = 0; k < 3; k++) step;
    chk("ds3_pre_count", 32'(count1), 32'h3);
    dready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h4000;
    step;
    redirect = 1'b0;
    chk("ds3_count", 32'(count1), 32'h1);
    chk("ds3_dinst", dinst1, 32'h3004);
    chk("ds3_iaddr", iaddr1, 32'h4000);
    step;
    chk("ds3_tgt_dinst", dinst1, 32'h4000);
    chk("ds3_tgt_dpc4", dpc41, 32'h4004);
    chk("ds3_tgt_count", 32'(count1), 32'h1);
    do_reset;
    irdy = 1'b1;
    step;
    irdy = 1'b0;
    dready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h5000;
    step;
    redirect = 1'b0;
    chk("pend_count", 32'(count1), 32'h0);
    chk("pend_iaddr", iaddr1, 32'h3004);
    chk("nods_count", 32'(count0), 32'h0);
    chk("nods_iaddr", iaddr0, 32'h5000);
    irdy = 1'b1;
    step;
    chk("pend_slot_dinst", dinst1, 32'h3004);
    chk("pend_slot_iaddr", iaddr1, 32'h5000);
    chk("nods_tgt_dinst", dinst0, 32'h5000);
    step;
    chk("pend_tgt_dinst", dinst1, 32'h5000);
    chk("pend_tgt_iaddr", iaddr1, 32'h5004);
    do_reset;
    irdy = 1'b1;
    for (int k = 0; k < 4; k++) step;
    chk("mid_full_count", 32'(count1), 32'h4);
    rst = 1'b0;
    step;
    rst = 1'b1;
    irdy = 1'b0;
    chk("mid_rst_count", 32'(count1), 32'h0);
    chk("mid_rst_dvalid", 32'(dvalid1), 32'h0);
    chk("mid_rst_dinst", dinst1, 32'h0);
    chk("mid_rst_iaddr", iaddr1, 32'h3000);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    dready = 1'b1;
    step;
    redirect = 1'b0;
    chk("wrap_pre_iaddr", iaddr1, 32'hFFFF_FFFC);
    irdy = 1'b1;
    step;
    chk("wrap_iaddr", iaddr1, 32'h0);
    chk("wrap_dinst", dinst1, 32'hFFFF_FFFC);
    chk("wrap_dpc4", dpc41, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
